// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - write, reserve and read bus bundle for reg_file_mp
interface reg_file_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
) ();
    logic                           WRITE1_ENABLE;
    logic [ADDR_WIDTH-1:0]          WRITE1_ADDRESS;
    logic [DATA_WIDTH-1:0]          WRITE1_DATA;
    logic                           WRITE2_ENABLE;
    logic [ADDR_WIDTH-1:0]          WRITE2_ADDRESS;
    logic [DATA_WIDTH-1:0]          WRITE2_DATA;
    logic                           RESERVE_ENABLE;
    logic [ADDR_WIDTH-1:0]          RESERVE_ADDRESS;
    logic [NUM_READ*ADDR_WIDTH-1:0] READ_ADDRESS;
    logic [NUM_READ*DATA_WIDTH-1:0] READ_DATA;
    logic [NUM_READ-1:0]            READ_BUSY;

    modport master (
        output WRITE1_ENABLE, WRITE1_ADDRESS, WRITE1_DATA,
        output WRITE2_ENABLE, WRITE2_ADDRESS, WRITE2_DATA,
        output RESERVE_ENABLE, RESERVE_ADDRESS, READ_ADDRESS,
        input  READ_DATA, READ_BUSY
    );

    modport slave (
        input  WRITE1_ENABLE, WRITE1_ADDRESS, WRITE1_DATA,
        input  WRITE2_ENABLE, WRITE2_ADDRESS, WRITE2_DATA,
        input  RESERVE_ENABLE, RESERVE_ADDRESS, READ_ADDRESS,
        output READ_DATA, READ_BUSY
    );
endinterface

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with busy scoreboard
// Optional same-cycle write-to-read forwarding when REG_FILE_BYPASS_EN is defined.
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    reg_file_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;

    logic [ADDR_WIDTH-1:0] rd_addr [NUM_READ];
    logic [DATA_WIDTH-1:0] rd_data [NUM_READ];
    logic                  rd_busy [NUM_READ];

    logic w1_ok;
    logic w2_ok;
    logic rsv_ok;

    function automatic logic addr_writable(input logic [ADDR_WIDTH-1:0] a);
        return !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_comb begin
        w1_ok  = bus.WRITE1_ENABLE  && addr_writable(bus.WRITE1_ADDRESS);
        w2_ok  = bus.WRITE2_ENABLE  && addr_writable(bus.WRITE2_ADDRESS);
        rsv_ok = bus.RESERVE_ENABLE && addr_writable(bus.RESERVE_ADDRESS);
    end

    // WRITE1 applied after WRITE2 so it wins a collision; reserve after clear so new issue wins.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
        end
        busy_d = busy_q;
        if (w2_ok) begin
            regs_d[bus.WRITE2_ADDRESS] = bus.WRITE2_DATA;
            busy_d[bus.WRITE2_ADDRESS] = 1'b0;
        end
        if (w1_ok) begin
            regs_d[bus.WRITE1_ADDRESS] = bus.WRITE1_DATA;
        end
        if (rsv_ok) begin
            busy_d[bus.RESERVE_ADDRESS] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_READ; k++) begin
            rd_addr[k] = bus.READ_ADDRESS[k*ADDR_WIDTH +: ADDR_WIDTH];
            rd_data[k] = regs_q[rd_addr[k]];
            rd_busy[k] = busy_q[rd_addr[k]];
`ifdef REG_FILE_BYPASS_EN
            if (w2_ok && (bus.WRITE2_ADDRESS == rd_addr[k])) begin
                rd_data[k] = bus.WRITE2_DATA;
                if (!(rsv_ok && (bus.RESERVE_ADDRESS == rd_addr[k]))) begin
                    rd_busy[k] = 1'b0;
                end
            end
            if (w1_ok && (bus.WRITE1_ADDRESS == rd_addr[k])) begin
                rd_data[k] = bus.WRITE1_DATA;
            end
`endif
        end
    end

    // Outputs are forced low while reset is held so forwarded inputs cannot leak out.
    always_comb begin
        bus.READ_DATA = '0;
        bus.READ_BUSY = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            bus.READ_DATA[k*DATA_WIDTH +: DATA_WIDTH] = RESET ? rd_data[k] : '0;
            bus.READ_BUSY[k]                          = RESET & rd_busy[k];
        end
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed self-checking bench for reg_file_mp
module tb_reg_file_mp;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    reg_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) bus ();

    reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        bus.READ_ADDRESS = {a1, a0};
    endtask

    task automatic idle();
        bus.WRITE1_ENABLE  = 1'b0;
        bus.WRITE2_ENABLE  = 1'b0;
        bus.RESERVE_ENABLE = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1 idle();
        #2;
    endtask

    function automatic logic [31:0] rd0();
        return bus.READ_DATA[31:0];
    endfunction

    function automatic logic [31:0] rd1();
        return bus.READ_DATA[63:32];
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        idle();
        bus.WRITE1_ADDRESS = '0; bus.WRITE1_DATA = '0;
        bus.WRITE2_ADDRESS = '0; bus.WRITE2_DATA = '0;
        bus.RESERVE_ADDRESS = '0;
        set_rd(5'd1, 5'd2);
        rst_n = 1'b0;
        #3;
        chk("reset_data0", rd0(), 32'h0);
        chk("reset_busy",  {30'b0, bus.READ_BUSY}, 32'h0);
        #2 rst_n = 1'b1;

        // Write reg1 = 10
        bus.WRITE1_ENABLE = 1'b1; bus.WRITE1_ADDRESS = 5'd1; bus.WRITE1_DATA = 32'd10;
        tick();
        chk("wr1_data", rd0(), 32'd10);
        chk("wr1_busy", {31'b0, bus.READ_BUSY[0]}, 32'h0);

        // x0 protection
        bus.WRITE1_ENABLE = 1'b1; bus.WRITE1_ADDRESS = 5'd0; bus.WRITE1_DATA = 32'hDEADBEEF;
        bus.RESERVE_ENABLE = 1'b1; bus.RESERVE_ADDRESS = 5'd0;
        set_rd(5'd0, 5'd0);
        #1;
        chk("x0_fwd_data", rd1(), 32'h0);
        tick();
        chk("x0_data0", rd0(), 32'h0);
        chk("x0_data1", rd1(), 32'h0);
        chk("x0_busy",  {30'b0, bus.READ_BUSY}, 32'h0);

        // Collision on reg5
        bus.WRITE1_ENABLE = 1'b1; bus.WRITE1_ADDRESS = 5'd5; bus.WRITE1_DATA = 32'h11;
        bus.WRITE2_ENABLE = 1'b1; bus.WRITE2_ADDRESS = 5'd5; bus.WRITE2_DATA = 32'h22;
        set_rd(5'd5, 5'd1);
        tick();
        chk("coll_data", rd0(), 32'h11);
        chk("alias_reg1", rd1(), 32'd10);

        // Scoreboard on reg7
        bus.RESERVE_ENABLE = 1'b1; bus.RESERVE_ADDRESS = 5'd7;
        set_rd(5'd1, 5'd7);
        tick();
        chk("sb_rsv_busy", {31'b0, bus.READ_BUSY[1]}, 32'h1);
        chk("sb_other_busy", {31'b0, bus.READ_BUSY[0]}, 32'h0);
        bus.RESERVE_ENABLE = 1'b1; bus.RESERVE_ADDRESS = 5'd7;
        bus.WRITE2_ENABLE = 1'b1; bus.WRITE2_ADDRESS = 5'd7; bus.WRITE2_DATA = 32'h55;
        tick();
        chk("sb_both_busy", {31'b0, bus.READ_BUSY[1]}, 32'h1);
        chk("sb_both_data", rd1(), 32'h55);
        bus.WRITE2_ENABLE = 1'b1; bus.WRITE2_ADDRESS = 5'd7; bus.WRITE2_DATA = 32'h66;
        tick();
        chk("sb_clr_busy", {31'b0, bus.READ_BUSY[1]}, 32'h0);
        chk("sb_clr_data", rd1(), 32'h66);

        // WRITE2 to a never-reserved register
        bus.WRITE2_ENABLE = 1'b1; bus.WRITE2_ADDRESS = 5'd8; bus.WRITE2_DATA = 32'hCAFE;
        set_rd(5'd8, 5'd8);
        tick();
        chk("w2_free_data", rd0(), 32'hCAFE);
        chk("w2_free_busy", {30'b0, bus.READ_BUSY}, 32'h0);

        // Same-cycle forwarding on reg4
        bus.WRITE1_ENABLE = 1'b1; bus.WRITE1_ADDRESS = 5'd4; bus.WRITE1_DATA = 32'h1234;
        set_rd(5'd1, 5'd4);
        #1;
`ifdef REG_FILE_BYPASS_EN
        chk("byp_pre_edge", rd1(), 32'h1234);
`else
        chk("byp_pre_edge", rd1(), 32'h0);
`endif
        tick();
        chk("byp_post_edge", rd1(), 32'h1234);

        // Asynchronous reset between edges
        bus.WRITE1_ENABLE = 1'b1; bus.WRITE1_ADDRESS = 5'd3; bus.WRITE1_DATA = 32'hAB;
        bus.RESERVE_ENABLE = 1'b1; bus.RESERVE_ADDRESS = 5'd9;
        set_rd(5'd3, 5'd9);
        tick();
        chk("pre_rst_data", rd0(), 32'hAB);
        chk("pre_rst_busy", {31'b0, bus.READ_BUSY[1]}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", rd0(), 32'h0);
        chk("async_rst_busy", {30'b0, bus.READ_BUSY}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_data", rd0(), 32'h0);
        chk("post_rst_busy", {30'b0, bus.READ_BUSY}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the pipeline register file: configurable data width and depth, NUM_READ asynchronous read ports, two write ports, and a per-register busy scoreboard.
- Sits in the ID/WB stages of the RV32IM pipeline.
- WRITE1 carries ALU/load writeback. WRITE2 carries the long-latency MUL/DIV writeback, whose destination is reserved at issue.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH.
- NUM_READ, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy; 0 = register 0 is ordinary.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- WRITE1_ENABLE  in  1  write port 1 enable (priority port).
- WRITE1_ADDRESS  in  ADDR_WIDTH  write port 1 address.
- WRITE1_DATA  in  DATA_WIDTH  write port 1 data.
- WRITE2_ENABLE  in  1  write port 2 enable (long-latency writeback; clears busy).
- WRITE2_ADDRESS  in  ADDR_WIDTH  write port 2 address.
- WRITE2_DATA  in  DATA_WIDTH  write port 2 data.
- RESERVE_ENABLE  in  1  mark a destination busy at MUL/DIV issue.
- RESERVE_ADDRESS  in  ADDR_WIDTH  register to reserve.
- READ_ADDRESS  in  NUM_READ*ADDR_WIDTH  flattened read addresses; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- READ_DATA  out  NUM_READ*DATA_WIDTH  flattened read data; port k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- READ_BUSY  out  NUM_READ  busy flag of each read port's addressed register.

Behaviour:
- Reset (RESET=0, asynchronous):
  - all registers cleared to 0 and all busy bits cleared;
  - READ_DATA = 0 and READ_BUSY = 0 while reset is held;
  - reset during a pending reservation discards it.
- Reads: combinational from the array; every port is independent and any addresses may alias.
- Writes: registered on the rising edge; the new value appears on READ_DATA after the edge (zero-cycle read latency).
- Port collision: both write ports enabled with the same address in one cycle → WRITE1_DATA is stored and WRITE2_DATA is dropped; the busy clear by WRITE2 still takes effect.
- Scoreboard:
  - busy[RESERVE_ADDRESS] set on the edge when RESERVE_ENABLE=1;
  - busy[WRITE2_ADDRESS] cleared on the edge when WRITE2_ENABLE=1;
  - WRITE1 never changes busy bits;
  - RESERVE and WRITE2 to the same address in one cycle → busy ends at 1 (new issue wins);
  - reserving an already-busy register keeps it busy; WRITE2 to a non-busy register is legal, writes the data, busy stays 0.
- ZERO_REG=1:
  - writes and reserves to address 0 are ignored;
  - reads of address 0 return 0 with busy 0.
- Widths: addresses use all ADDR_WIDTH bits with no out-of-range case; data is stored unmodified.

Optional Feature:
- Macro REG_FILE_BYPASS_EN.
- Defined → same-cycle write-to-read forwarding:
  - a read whose address matches an enabled write returns that write's data combinationally, with WRITE1 taking priority over WRITE2;
  - READ_BUSY reads 0 if WRITE2 matches the address and RESERVE does not match it in the same cycle;
  - address 0 is never forwarded when ZERO_REG=1.
- Undefined → READ_DATA and READ_BUSY reflect registered state only; new values appear after the edge.

Test Plan:
- Reset then write: RESET low 5 ns then high; WRITE1 reg1=32'd10 at an edge; read port 0 addr 1 3 ns after the edge → READ_DATA[31:0]=10, READ_BUSY[0]=0.
- x0 protection: WRITE1 reg0=32'hDEADBEEF and RESERVE reg0 → all ports reading addr 0 return 0 with busy 0 (ZERO_REG=1).
- Collision: same edge, WRITE1 reg5=32'h11 and WRITE2 reg5=32'h22 → reg5 reads 32'h11.
- Scoreboard: RESERVE reg7 → READ_BUSY=1 on a port reading 7. Next edge with RESERVE reg7 and WRITE2 reg7=32'h55 → busy stays 1, data 32'h55. Then WRITE2 reg7=32'h66 alone → busy 0, data 32'h66.
- Async reset mid-operation: reg3=32'hAB and reg9 busy; pull RESET low between clock edges → READ_DATA=0 and READ_BUSY=0 immediately, before the next edge.
- Bypass (REG_FILE_BYPASS_EN defined): WRITE1 reg4=32'h1234 with port 1 reading 4 before the edge → READ_DATA port 1 = 32'h1234 in the same cycle. With the macro undefined → old value until the edge.
